// File: rtl/complement_gate_mw.sv
// complement_gate_mw: serial sign-magnitude/complement gate from the early bus to the intermediate bus; CGATE_FRAME_CHECK_EN enables the framing check.
module complement_gate_mw #(
  parameter int WORD_BITS = 29,
  parameter int WORDS = 2,
  localparam int BW = $clog2(WORD_BITS),
  localparam int WW = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic          CLOCK,
  input  logic          rst,
  input  logic          EB_IN,
  input  logic          BLOCK_SYNC,
  input  logic          WORD_SYNC,
  input  logic          XFER,
  input  logic [1:0]    MODE,
  input  logic          FRAME_CLR,
  output logic          IB,
  output logic          SIGN_OUT,
  output logic          MZERO,
  output logic          FRAME_ERR,
  output logic          BUSY,
  output logic [BW-1:0] BIT_POS,
  output logic [WW-1:0] WORD_IDX
);
  typedef enum logic [1:0] {IDLE, PASS, COPY, INVERT} state_t;
  state_t state, state_n;
  logic [BW-1:0] pred_bit, cur_bit;
  logic [WW-1:0] pred_word, cur_word;
  logic bit_wrap, last, start, neg, sign_e, ib_n, mz_n;
  // BIT_POS/WORD_IDX name the bit now on IB; pred_* is where the incoming bit should sit
  assign bit_wrap = BIT_POS == BW'(WORD_BITS - 1);
  assign pred_bit = bit_wrap ? '0 : BIT_POS + 1'b1;
  assign pred_word = !bit_wrap ? WORD_IDX : (WORD_IDX == WW'(WORDS - 1)) ? '0 : WORD_IDX + 1'b1;
  assign cur_word = BLOCK_SYNC ? '0 : pred_word;
`ifdef CGATE_FRAME_CHECK_EN
  logic locked, frame_set;
  assign cur_bit = (BLOCK_SYNC || WORD_SYNC) ? '0 : pred_bit;
  assign frame_set = locked && ((WORD_SYNC && pred_bit != '0) ||
                                (BLOCK_SYNC && (pred_bit != '0 || pred_word != '0)));
  // no prediction exists until the first block sync after reset
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      locked <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      locked <= locked | BLOCK_SYNC;
      FRAME_ERR <= frame_set | (FRAME_ERR & ~FRAME_CLR);
    end
  end
`else
  logic unused_frame;
  assign unused_frame = WORD_SYNC ^ FRAME_CLR;
  assign cur_bit = BLOCK_SYNC ? '0 : pred_bit;
  assign FRAME_ERR = 1'b0;
`endif
  assign last = (cur_bit == BW'(WORD_BITS - 1)) && (cur_word == WW'(WORDS - 1));
  assign start = XFER && BLOCK_SYNC;
  assign neg = (MODE == 2'b00) ? 1'b0 : (MODE == 2'b10) ? 1'b1 : EB_IN;
  assign sign_e = MODE[1] ? (~MODE[0] & ~EB_IN) : EB_IN;
  assign BUSY = state != IDLE;
  // two's complement serially: copy up to and including the first one, invert afterwards
  always_comb begin
    state_n = state;
    ib_n = 1'b0;
    mz_n = 1'b0;
    if (!XFER) state_n = IDLE;
    else if (start) begin
      ib_n = sign_e;
      state_n = neg ? COPY : PASS;
    end else if (state != IDLE) begin
      ib_n = (state == INVERT) ? ~EB_IN : EB_IN;
      state_n = (state == COPY && EB_IN) ? INVERT : state;
      if (last) begin
        state_n = IDLE;
        mz_n = (state == COPY) && !EB_IN;
      end
    end
  end
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state <= IDLE;
      BIT_POS <= '0;
      WORD_IDX <= '0;
      IB <= 1'b0;
      SIGN_OUT <= 1'b0;
      MZERO <= 1'b0;
    end else begin
      state <= state_n;
      BIT_POS <= cur_bit;
      WORD_IDX <= cur_word;
      IB <= ib_n;
      MZERO <= mz_n;
      if (start) SIGN_OUT <= sign_e;
    end
  end
endmodule

// File: doc/complement_gate_mw.md
COMPLEMENT_GATE_MW -- requirements
Module: complement_gate_mw

Interface
REQ-001 Parameter WORD_BITS, default 29, shall set the serial word length in bits, legal range 4..64.
REQ-002 Parameter WORDS, default 2, shall set the number of words per block, legal range 1..4.
REQ-003 Port CLOCK, input, 1, shall be the single clock; all state shall update on its rising edge.
REQ-004 Port rst, input, 1, shall be the reset; reset is synchronous and active-high.
REQ-005 Port EB_IN, input, 1, shall carry the serial early-bus data bit, LSB first.
REQ-006 Port BLOCK_SYNC, input, 1, shall be high on bit 0 of word 0 of each block.
REQ-007 Port WORD_SYNC, input, 1, shall be high on bit 0 of every word, i.e. sign time.
REQ-008 Port XFER, input, 1, shall enable the transfer; when low, the gate is idle.
REQ-009 Port MODE, input, 2, shall select the operation: 00 pass, 01 sign-magnitude to complement, 10 negate, 11 absolute value.
REQ-010 Port FRAME_CLR, input, 1, shall clear FRAME_ERR.
REQ-011 Port IB, output, 1, shall carry the registered serial intermediate-bus bit.
REQ-012 Port SIGN_OUT, output, 1, shall hold the sign emitted for the current block.
REQ-013 Port MZERO, output, 1, shall be a one-clock minus-zero pulse.
REQ-014 Port FRAME_ERR, output, 1, shall be a sticky sync error flag.
REQ-015 Port BUSY, output, 1, shall be high when the state is not IDLE.
REQ-016 Port BIT_POS, output, $clog2(WORD_BITS), shall give the current bit position.
REQ-017 Port WORD_IDX, output, max(1,$clog2(WORDS)), shall give the current word index.

Function
REQ-018 The counters shall load 0/0 on BLOCK_SYNC; otherwise BIT_POS shall increment, wrapping at WORD_BITS-1 into WORD_IDX+1, and WORD_IDX shall wrap at WORDS-1.
REQ-019 The state machine shall have states IDLE, PASS, COPY and INVERT.
REQ-020 At BLOCK_SYNC with XFER=1, the block shall capture sign S=EB_IN and latch MODE; MODE changes mid-block shall be ignored.
REQ-021 The negate flag N shall be 0 for mode 00, S for mode 01, 1 for mode 10, and S for mode 11.
REQ-022 The emitted sign shall be S for mode 00, S for mode 01, ~S for mode 10, and 0 for mode 11.
REQ-023 At the sync cycle, IB shall take the emitted sign, and the next state shall be COPY if N=1, else PASS.
REQ-024 In PASS, IB shall equal EB_IN.
REQ-025 In COPY, IB shall equal EB_IN, and EB_IN=1 shall move the state to INVERT.
REQ-026 In INVERT, IB shall equal ~EB_IN.
REQ-027 The complement carry shall span word boundaries; bit 0 of words 1..WORDS-1 shall be treated as magnitude.
REQ-028 On the last bit of the last word, the state shall return to IDLE; a coincident BLOCK_SYNC with XFER=1 shall start the next block with no gap cycle.
REQ-029 If N=1 and the state is still COPY at the block's last bit, MZERO shall pulse, aligned with that bit on IB.
REQ-030 IB, SIGN_OUT and MZERO shall be registered with a latency of exactly 1 clock from EB_IN.
REQ-031 In IDLE, or whenever XFER=0, IB shall be 0.
REQ-032 XFER falling mid-block shall force IDLE at the next edge.

Reset
REQ-033 While rst=1, at the edge: state=IDLE, counters=0, and IB, SIGN_OUT, MZERO, FRAME_ERR and BUSY=0; rst shall override all other inputs, including mid-block.

Configuration
REQ-034 The macro CGATE_FRAME_CHECK_EN shall control the framing check; when defined, FRAME_ERR shall set if WORD_SYNC arrives with predicted BIT_POS!=0, or BLOCK_SYNC with predicted position !=(0,0); the counters shall then resynchronise, and set shall win over a simultaneous FRAME_CLR.
REQ-035 When CGATE_FRAME_CHECK_EN is undefined, FRAME_ERR shall be tied 0, WORD_SYNC shall be ignored, and the counters shall still resynchronise on BLOCK_SYNC.

Verification (WORD_BITS=29, WORDS=2)
REQ-036 Mode 01, S=1, magnitude 0x0000004 in word 0 -> IB shall carry sign 1, bits 1..3 copied, then all remaining 54 bits inverted, with MZERO=0.
REQ-037 Mode 01, S=1, all magnitude zero -> IB shall equal the input unchanged, MZERO shall pulse at the output of bit 28 of word 1, and BUSY shall drop.
REQ-038 Mode 10, S=0, first 1 at word 1 bit 0 -> word 0 shall copy zeros, the carry shall cross into word 1, and SIGN_OUT shall be 1.
REQ-039 Mode 11, S=1 -> sign output 0; mode 11, S=0 -> output identical to input, delayed 1 clock.
REQ-040 XFER dropped at word 0 bit 10 -> IB=0 from the next output onward, and BUSY=0.
REQ-041 With CGATE_FRAME_CHECK_EN defined, WORD_SYNC at bit 15 -> FRAME_ERR=1 persists until FRAME_CLR, and a simultaneous error and FRAME_CLR -> FRAME_ERR stays 1.
